// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-entry skid buffer and branch redirect.
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   stall               - downstream not accepting; output consumed when inst_valid && !stall
//   br_taken, br_target - redirect request and new PC
//   imem_req, imem_addr - instruction-memory request; address is always the PC register
//   imem_ack, imem_rdata- memory response and instruction word
//   pc_out, inst_out    - presented instruction and its PC
//   inst_valid          - qualifies pc_out/inst_out
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_pc_out;
    logic [31:0] r_inst_out;
    logic        r_valid;
    logic        w_free;
    assign w_free     = !r_valid || !stall;
    assign imem_req   = (r_state == REQ);
    assign imem_addr  = r_pc;
    assign pc_out     = r_pc_out;
    assign inst_out   = r_inst_out;
    assign inst_valid = r_valid;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_pc_out    <= '0;
            r_inst_out  <= '0;
            r_valid     <= 1'b0;
        end else if (br_taken) begin
            // Redirect flushes both the output slot and the skid entry; any ack this cycle is dropped.
            r_state     <= IDLE;
            r_pc        <= br_target;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        r_pc <= r_pc + PC_STEP;
                        if (w_free) begin
                            r_pc_out   <= r_pc;
                            r_inst_out <= imem_rdata;
                            r_valid    <= 1'b1;
                        end else begin
                            // Output still held by a stall: park the word and stop requesting.
                            r_skid_pc   <= r_pc;
                            r_skid_inst <= imem_rdata;
                            r_state     <= HOLD;
                        end
                    end else if (!stall) begin
                        r_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (w_free) begin
                        r_pc_out   <= r_skid_pc;
                        r_inst_out <= r_skid_inst;
                        r_valid    <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage.
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'hFFFF_FFFE;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    item_t       q[$];
    int          total = 0;
    int          bad = 0;
    logic        started = 1'b0;
    logic        idle = 1'b1;
    logic        rst_applied = 1'b0;
    logic        req_exp = 1'b0;
    logic [31:0] mpc = RPC;

    fetch_stage #(.RESET_PC(RPC), .PC_STEP(32'd1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    // Memory: instruction word is a fixed function of the address.
    assign imem_rdata = imem_addr * 32'd7 + 32'd100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd7 + 32'd100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: checks handshake outputs and pops the scoreboard on each consumed instruction.
    always begin
        item_t it;
        @(negedge clk);
        #3;
        if (started) begin
            req_exp = !idle && (q.size() < 2);
            chk("imem_req", 32'(imem_req), 32'(req_exp));
            chk("inst_valid", 32'(inst_valid), 32'(q.size() > 0));
            if (rst_applied) begin
                chk("rst_pc_out", pc_out, 32'd0);
                chk("rst_inst_out", inst_out, 32'd0);
            end
            if (inst_valid && !stall) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst got_pc=%h want=none", pc_out);
                end else begin
                    it = q.pop_front();
                    chk("pc_out", pc_out, it.pc);
                    chk("inst_out", inst_out, it.inst);
                end
            end
        end
    end

    // Reference model: a fetch happens whenever a request is outstanding and acked without a redirect.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            q.delete();
            mpc = RPC;
            idle = 1'b1;
            rst_applied = 1'b1;
            started = 1'b1;
        end else begin
            rst_applied = 1'b0;
            if (started) begin
                chk("imem_addr", imem_addr, mpc);
                if (br_taken) begin
                    q.delete();
                    mpc = br_target;
                    idle = 1'b1;
                end else begin
                    if (req_exp && imem_ack) begin
                        q.push_back('{pc: mpc, inst: mem_word(mpc)});
                        mpc = mpc + 32'd1;
                    end
                    idle = 1'b0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        stall = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            imem_ack = (i % 3 == 2);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            imem_ack = 1'($urandom % 2);
            stall = ($urandom % 3 == 0);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom % 150 != 0);
            br_taken = ($urandom % 12 == 0);
            case ($urandom % 4)
                0: br_target = 32'hFFFF_FFFF - 32'($urandom % 2);
                1: br_target = 32'd40;
                default: br_target = $urandom;
            endcase
            imem_ack = ($urandom % 4 != 0);
            stall = ($urandom % 3 == 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        stall = 1'b0;
        repeat (10) @(negedge clk);
        #5;
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'd0, SHALL be the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd1, SHALL be the PC increment per fetched instruction (word-addressed).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 stall  input  1  SHALL indicate that downstream IF_ID is not accepting; the output is consumed on a cycle with inst_valid=1 and stall=0.
REQ-006 br_taken  input  1  SHALL be the redirect request from the EX_MEM branch decision (ZERO and branch).
REQ-007 br_target  input  32  SHALL be the redirect PC (EX_MEM adder output).
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  32  SHALL be the instruction-memory address, equal to the internal PC.
REQ-010 imem_ack  input  1  SHALL indicate that imem_rdata is valid for the current request.
REQ-011 imem_rdata  input  32  SHALL be the instruction word.
REQ-012 pc_out  output  32  SHALL be the PC of the presented instruction, fed to IF_ID PC input.
REQ-013 inst_out  output  32  SHALL be the presented instruction, fed to IF_ID instruction input.
REQ-014 inst_valid  output  1  SHALL qualify pc_out/inst_out.

Function
REQ-015 The block SHALL have states IDLE, REQ and HOLD; the output slot is free when inst_valid=0 or stall=0.
REQ-016 imem_req SHALL be 1 only in REQ; imem_addr SHALL equal the PC register in every state.
REQ-017 In REQ, imem_req and imem_addr SHALL stay stable until imem_ack; the only exception is a redirect.
REQ-018 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-019 In REQ with imem_ack=1 and the slot free, the block SHALL load pc_out<=PC, inst_out<=imem_rdata and inst_valid<=1, advance PC<=PC+PC_STEP, and stay in REQ (one instruction per cycle with a zero-wait memory).
REQ-020 In REQ with imem_ack=1 and the slot not free, the block SHALL capture {PC, imem_rdata} in a one-entry skid register, advance PC, and go to HOLD.
REQ-021 In REQ with imem_ack=0, the block SHALL clear inst_valid if the output was consumed this cycle; otherwise it SHALL hold the outputs.
REQ-022 In HOLD, when the slot is free, the block SHALL move the skid register to the outputs with inst_valid<=1 and go to REQ; otherwise it SHALL hold everything.
REQ-023 On br_taken=1 in any state, the block SHALL set PC<=br_target, inst_valid<=0, clear the skid register and go to IDLE; any imem_ack in that cycle SHALL be discarded.
REQ-024 Priority SHALL be rst_n, then br_taken, then stall/ack handling.
REQ-025 PC arithmetic SHALL be unsigned 32-bit and wrap modulo 2^32 (32'hFFFFFFFF + 1 = 0).
REQ-026 pc_out and inst_out SHALL be held unchanged whenever inst_valid=1 and stall=1.
REQ-027 No instruction SHALL be dropped or duplicated except those flushed by a redirect.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, PC=RESET_PC, pc_out=0, inst_out=0, inst_valid=0 and clear the skid register.
REQ-029 imem_req SHALL be 0 during reset and in the first cycle after reset release.
REQ-030 Reset asserted mid-transaction SHALL abandon the request; a late imem_ack SHALL be ignored while in IDLE.

Verification
REQ-031 Reset release, imem_ack tied 1, imem_rdata=PC+100, stall=0 -> imem_req high from cycle 2; pc_out/inst_out = 0/100, 1/101, 2/102 on consecutive cycles.
REQ-032 imem_ack asserted every third cycle -> inst_valid pulses once per 3 cycles with PCs 0, 1, 2 in order and no gaps in the PC sequence.
REQ-033 stall=1 for 3 cycles while inst_valid=1 (pc_out=1) and memory acks PC=2 -> state HOLD, imem_req=0, pc_out stays 1; after stall drops pc_out=2, then 3.
REQ-034 br_taken=1 with br_target=40 while in REQ with an ack present -> that ack is dropped, inst_valid=0, one IDLE cycle, then imem_addr=40 and pc_out=40 on the following ack.
REQ-035 RESET_PC=32'hFFFFFFFF, zero-wait memory -> pc_out sequence FFFFFFFF, 0, 1.
REQ-036 rst_n=0 asserted while in HOLD -> next cycle all outputs 0, imem_req=0, PC=RESET_PC.
